// File: rtl/phys_reg_free_list_mp_if.sv
// Rename-stage free-list bus: dispatch dequeue, ROB/kill frees, BRU checkpoints.
// Latency: n/a (signal bundle only).
// Backpressure: dequeue_valid / save_checkpoint_ready gate consumers; frees are never stalled.
interface phys_reg_free_list_mp_if #(
   parameter int NUM_PHYS_REGS      = 64,
   parameter int FREE_LIST_DEPTH    = 64,
   parameter int CHECKPOINT_COLUMNS = 4,
   parameter int ENQ_PORTS          = 2
);
   localparam int PRW = $clog2(NUM_PHYS_REGS);
   localparam int LD  = $clog2(FREE_LIST_DEPTH);
   localparam int LC  = $clog2(CHECKPOINT_COLUMNS);

   logic                          dequeue_valid;
   logic [PRW-1:0]                dequeue_phys_reg_tag;
   logic                          dequeue_ready;
   logic [ENQ_PORTS-1:0]          enqueue_valid;
   logic [ENQ_PORTS-1:0][PRW-1:0] enqueue_phys_reg_tag;
   logic                          save_checkpoint_valid;
   logic                          save_checkpoint_ready;
   logic [LC-1:0]                 save_checkpoint_column;
   logic                          commit_checkpoint_valid;
   logic                          restore_checkpoint_valid;
   logic [LC-1:0]                 restore_checkpoint_column;
   logic [LD:0]                   free_count;
   logic                          overflow_error;

   // The free list itself.
   modport slave (
      output dequeue_valid, dequeue_phys_reg_tag, save_checkpoint_ready,
             save_checkpoint_column, free_count, overflow_error,
      input  dequeue_ready, enqueue_valid, enqueue_phys_reg_tag, save_checkpoint_valid,
             commit_checkpoint_valid, restore_checkpoint_valid, restore_checkpoint_column
   );

   // Rename / commit / branch logic driving the free list.
   modport master (
      input  dequeue_valid, dequeue_phys_reg_tag, save_checkpoint_ready,
             save_checkpoint_column, free_count, overflow_error,
      output dequeue_ready, enqueue_valid, enqueue_phys_reg_tag, save_checkpoint_valid,
             commit_checkpoint_valid, restore_checkpoint_valid, restore_checkpoint_column
   );
endinterface

// File: rtl/phys_reg_free_list_mp.sv
// Physical-register free list: one alloc/cycle, ENQ_PORTS frees/cycle, checkpointed head rewind.
// Latency: outputs are registered state only; a free or restore in cycle N is visible in N+1.
// Backpressure: dequeue only while non-empty, save only while a column is free; frees beyond capacity are dropped and flagged.
module phys_reg_free_list_mp #(
   parameter int NUM_PHYS_REGS      = 64,
   parameter int NUM_ARCH_REGS      = 32,
   parameter int FREE_LIST_DEPTH    = 64,  // power of 2, >= NUM_PHYS_REGS
   parameter int CHECKPOINT_COLUMNS = 4,   // power of 2, >= 2
   parameter int ENQ_PORTS          = 2
) (
   input logic                       CLK,
   input logic                       nRST,
   phys_reg_free_list_mp_if.slave    bus
);
   localparam int PRW = $clog2(NUM_PHYS_REGS);
   localparam int LD  = $clog2(FREE_LIST_DEPTH);
   localparam int LC  = $clog2(CHECKPOINT_COLUMNS);

   localparam logic [LD:0] DEPTH_W     = (LD+1)'(FREE_LIST_DEPTH);
   localparam logic [LD:0] INIT_TAIL   = (LD+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
   localparam logic [LD:0] ONE_LD      = (LD+1)'(1);
   localparam logic [LC:0] COLS_W      = (LC+1)'(CHECKPOINT_COLUMNS);
   localparam logic [LC:0] ONE_LC      = (LC+1)'(1);

   // Storage: tag ring plus one saved head pointer per checkpoint column.
   logic [PRW-1:0] mem     [FREE_LIST_DEPTH];
   logic [LD:0]    ck_mem  [CHECKPOINT_COLUMNS];
   logic [LD:0]    head, tail;
   logic [LC:0]    ck_head, ck_tail;
   logic           overflow_q;

   // Combinational control.
   logic                 deq_fire;
   logic [LD:0]          head_deq;
   logic [LD:0]          space;
   logic [LD:0]          n_acc;
   logic                 drop;
   logic [ENQ_PORTS-1:0] wr_en;
   logic [LD-1:0]        wr_idx [ENQ_PORTS];
   logic [LC:0]          ck_alloc;
   logic                 save_ready;
   logic                 save_fire;
   logic                 commit_fire;
   logic [LC-1:0]        col_off;
   logic                 restore_ok;

   assign ck_alloc    = ck_tail - ck_head;
   assign save_ready  = (ck_alloc != COLS_W);
   assign deq_fire    = (head != tail) && bus.dequeue_ready && !bus.restore_checkpoint_valid;
   assign head_deq    = head + {{LD{1'b0}}, deq_fire};
   // Room left once this cycle's allocation has left the list.
   assign space       = DEPTH_W - (tail - head_deq);
   assign save_fire   = bus.save_checkpoint_valid && save_ready && !bus.restore_checkpoint_valid;
   assign commit_fire = bus.commit_checkpoint_valid && (ck_alloc != '0);
   // Age of the requested column relative to the oldest allocated one.
   assign col_off     = bus.restore_checkpoint_column - ck_head[LC-1:0];
   // A restore of the column retiring this very cycle has nothing left to rewind to.
   assign restore_ok  = bus.restore_checkpoint_valid && ({1'b0, col_off} < ck_alloc) &&
                        !(commit_fire && (col_off == '0));

   // Compact valid free ports into consecutive tail slots; anything past capacity is dropped.
   always_comb begin
      n_acc = '0;
      drop  = 1'b0;
      for (int p = 0; p < ENQ_PORTS; p++) begin
         wr_en[p]  = 1'b0;
         wr_idx[p] = '0;
         if (bus.enqueue_valid[p]) begin
            if (n_acc < space) begin
               wr_en[p]  = 1'b1;
               wr_idx[p] = tail[LD-1:0] + n_acc[LD-1:0];
               n_acc     = n_acc + ONE_LD;
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   // Tag ring: reset holds the unmapped registers in ascending order; frees land at the tail.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
            mem[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? PRW'(NUM_ARCH_REGS + i) : '0;
         end
      end else begin
         for (int p = 0; p < ENQ_PORTS; p++) begin
            if (wr_en[p]) begin
               mem[wr_idx[p]] <= bus.enqueue_phys_reg_tag[p];
            end
         end
      end
   end

   // Checkpoint columns capture the head as it stands after this cycle's allocation.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
            ck_mem[c] <= '0;
         end
      end else if (save_fire) begin
         ck_mem[ck_tail[LC-1:0]] <= head_deq;
      end
   end

   // Pointer update: restore overrides the head and trims younger columns; frees always advance the tail.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head       <= '0;
         tail       <= INIT_TAIL;
         ck_head    <= '0;
         ck_tail    <= '0;
         overflow_q <= 1'b0;
      end else begin
         tail <= tail + n_acc;
         if (drop) begin
            overflow_q <= 1'b1;
         end
         if (commit_fire) begin
            ck_head <= ck_head + ONE_LC;
         end
         if (restore_ok) begin
            head    <= ck_mem[bus.restore_checkpoint_column];
            ck_tail <= ck_head + {1'b0, col_off};
         end else begin
            head <= head_deq;
            if (save_fire) begin
               ck_tail <= ck_tail + ONE_LC;
            end
         end
      end
   end

   assign bus.dequeue_valid          = (head != tail);
   assign bus.dequeue_phys_reg_tag   = mem[head[LD-1:0]];
   assign bus.free_count             = tail - head;
   assign bus.save_checkpoint_ready  = save_ready;
   assign bus.save_checkpoint_column = ck_tail[LC-1:0];
   assign bus.overflow_error         = overflow_q;

endmodule
